alu_share_arbiter: RTL and testbench

Sequencer that shares one combinational `alu` datapath among `NREQ` requesters (e.g. integer pipe, branch-compare unit, address-gen, CSR unit). It round-robin arbitrates valid/ready requests and registers the winner into an issue stage that drives the ALU operand and control ports. It then captures ALU outputs into a response stage returned on a single tagged valid/ready channel. Throughput is one operation per cycle; fixed latency is 2 cycles when unstalled.

---
 rtl/alu_share_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Shares one external combinational ALU among NREQ requesters. A round-robin
// arbiter picks one valid request per cycle. The winner is registered into an
// issue stage (S1), which drives the ALU ports directly. The ALU outputs are
// captured into a response stage (S2), which is returned on one tagged
// valid/ready channel.
// Unstalled latency is 2 cycles, and throughput is one operation per cycle.
//
// Ports
//   clk, rst_n            : clock (rising edge), asynchronous active-low reset
//   flush                 : synchronous kill of everything in flight
//   req_valid/req_ready   : per-requester handshake (ready is one-hot or zero)
//   req_a/req_b/req_op    : packed per-requester operands (32/32/4 bits each)
//   alu_a/alu_b/alu_control : to the shared ALU, straight from S1 registers
//   alu_result/alu_zero/alu_lt/alu_ltu : from the shared ALU
//   rsp_valid/rsp_ready   : response handshake
//   rsp_id                : originating requester index
//   rsp_result/rsp_zero/rsp_lt/rsp_ltu : registered ALU outputs
//   rsp_err               : the operation code was not a legal ALU code
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*32-1:0]  req_a,
    input  logic [NREQ*32-1:0]  req_b,
    input  logic [NREQ*4-1:0]   req_op,
    output logic [31:0]         alu_a,
    output logic [31:0]         alu_b,
    output logic [3:0]          alu_control,
    input  logic [31:0]         alu_result,
    input  logic                alu_zero,
    input  logic                alu_lt,
    input  logic                alu_ltu,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [31:0]         rsp_result,
    output logic                rsp_zero,
    output logic                rsp_lt,
    output logic                rsp_ltu,
    output logic                rsp_err
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic           s1_valid_reg;
    logic [IDW-1:0] s1_id_reg;
    logic [31:0]    s1_a_reg;
    logic [31:0]    s1_b_reg;
    logic [3:0]     s1_op_reg;

    logic           rsp_valid_reg;
    logic [IDW-1:0] rsp_id_reg;
    logic [31:0]    rsp_result_reg;
    logic           rsp_zero_reg;
    logic           rsp_lt_reg;
    logic           rsp_ltu_reg;
    logic           rsp_err_reg;

    logic [IDW-1:0] rr_ptr_reg;

    // ------------------------------------------------------------------
    // Pipeline advance conditions
    // ------------------------------------------------------------------
    logic s2_adv;
    logic s1_adv;

    assign s2_adv = !rsp_valid_reg || rsp_ready;
    assign s1_adv = !s1_valid_reg || s2_adv;

    // ------------------------------------------------------------------
    // Per-requester operand unpacking
    // ------------------------------------------------------------------
    logic [31:0] a_arr  [NREQ];
    logic [31:0] b_arr  [NREQ];
    logic [3:0]  op_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign a_arr[gi]  = req_a[32*gi +: 32];
        assign b_arr[gi]  = req_b[32*gi +: 32];
        assign op_arr[gi] = req_op[4*gi +: 4];
    end

    // ------------------------------------------------------------------
    // Round-robin arbitration
    //
    // Duplicating the valid vector and slicing it at rr_ptr gives a view in
    // which bit k is requester (rr_ptr + k) mod NREQ. A fixed-priority pick on
    // that view is then the round-robin pick.
    // ------------------------------------------------------------------
    logic [2*NREQ-1:0] dbl_valid;
    logic [NREQ-1:0]   rot_valid;
    logic              hit;
    logic [IDW-1:0]    offset;
    logic [IDW:0]      winner_sum;
    logic [IDW-1:0]    winner;
    logic [IDW-1:0]    winner_inc;
    logic              grant;

    assign dbl_valid = {req_valid, req_valid};
    assign rot_valid = dbl_valid[rr_ptr_reg +: NREQ];

    always_comb begin
        hit    = 1'b0;
        offset = '0;
        // Descending scan: the last assignment wins, so the lowest offset wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot_valid[k]) begin
                hit    = 1'b1;
                offset = IDW'(k);
            end
        end
    end

    always_comb begin
        winner_sum = {1'b0, rr_ptr_reg} + {1'b0, offset};
        if (winner_sum >= (IDW+1)'(NREQ)) begin
            winner_sum = winner_sum - (IDW+1)'(NREQ);
        end
        winner = winner_sum[IDW-1:0];
    end

    assign winner_inc = (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);

    // flush blocks any grant, so nothing is accepted in the flush cycle.
    assign grant = hit && s1_adv && !flush;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
        assign req_ready[gi] = grant && (winner == IDW'(gi));
    end

    // ------------------------------------------------------------------
    // Legal ALU codes: 0000-0110 and 1000-1010
    // ------------------------------------------------------------------
    logic s1_op_legal;

    assign s1_op_legal = (s1_op_reg <= 4'd6) ||
                         ((s1_op_reg >= 4'd8) && (s1_op_reg <= 4'd10));

    // ------------------------------------------------------------------
    // Issue stage (S1) and round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_id_reg    <= '0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
            s1_op_reg    <= '0;
            rr_ptr_reg   <= '0;
        end else if (flush) begin
            s1_valid_reg <= 1'b0;
        end else if (s1_adv) begin
            s1_valid_reg <= grant;
            if (grant) begin
                s1_id_reg  <= winner;
                s1_a_reg   <= a_arr[winner];
                s1_b_reg   <= b_arr[winner];
                s1_op_reg  <= op_arr[winner];
                rr_ptr_reg <= winner_inc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Response stage (S2)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_reg  <= 1'b0;
            rsp_id_reg     <= '0;
            rsp_result_reg <= '0;
            rsp_zero_reg   <= 1'b0;
            rsp_lt_reg     <= 1'b0;
            rsp_ltu_reg    <= 1'b0;
            rsp_err_reg    <= 1'b0;
        end else if (flush) begin
            rsp_valid_reg <= 1'b0;
        end else if (s1_valid_reg && s2_adv) begin
            rsp_valid_reg  <= 1'b1;
            rsp_id_reg     <= s1_id_reg;
            rsp_result_reg <= alu_result;
            rsp_zero_reg   <= alu_zero;
            rsp_lt_reg     <= alu_lt;
            rsp_ltu_reg    <= alu_ltu;
            rsp_err_reg    <= !s1_op_legal;
        end else if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: the ALU ports come straight from the S1 registers.
    // ------------------------------------------------------------------
    assign alu_a       = s1_a_reg;
    assign alu_b       = s1_b_reg;
    assign alu_control = s1_op_reg;

    assign rsp_valid  = rsp_valid_reg;
    assign rsp_id     = rsp_id_reg;
    assign rsp_result = rsp_result_reg;
    assign rsp_zero   = rsp_zero_reg;
    assign rsp_lt     = rsp_lt_reg;
    assign rsp_ltu    = rsp_ltu_reg;
    assign rsp_err    = rsp_err_reg;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// Bench for alu_share_arbiter with NREQ=4. A behavioural ALU is attached to the
// ALU ports. The reference model treats the block as a capacity-2 in-order
// pipe. Each accepted op is pushed into a queue with its expected result. An
// entry becomes visible as a response one cycle after it is granted, and it
// leaves the queue on a response handshake. The round-robin winner is
// computed with modulo arithmetic from a model pointer.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = $clog2(NREQ);

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                flush = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*32-1:0]  req_a = '0;
    logic [NREQ*32-1:0]  req_b = '0;
    logic [NREQ*4-1:0]   req_op = '0;
    logic [31:0]         alu_a;
    logic [31:0]         alu_b;
    logic [3:0]          alu_control;
    logic [31:0]         alu_result;
    logic                alu_zero;
    logic                alu_lt;
    logic                alu_ltu;
    logic                rsp_valid;
    logic                rsp_ready = 1'b0;
    logic [IDW-1:0]      rsp_id;
    logic [31:0]         rsp_result;
    logic                rsp_zero;
    logic                rsp_lt;
    logic                rsp_ltu;
    logic                rsp_err;

    always #5 clk = ~clk;

    alu_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .alu_lt      (alu_lt),
        .alu_ltu     (alu_ltu),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .rsp_zero    (rsp_zero),
        .rsp_lt      (rsp_lt),
        .rsp_ltu     (rsp_ltu),
        .rsp_err     (rsp_err)
    );

    // ------------------------------------------------------------------
    // Behavioural ALU
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        lt;
        logic        ltu;
        logic        err;
    } alu_out_t;

    function automatic alu_out_t alu_fn(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op);
        alu_out_t o;
        o.err = 1'b0;
        case (op)
            4'd0:    o.res = a + b;
            4'd1:    o.res = a - b;
            4'd2:    o.res = a & b;
            4'd3:    o.res = a | b;
            4'd4:    o.res = a ^ b;
            4'd5:    o.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:    o.res = (a < b) ? 32'd1 : 32'd0;
            4'd8:    o.res = a << b[4:0];
            4'd9:    o.res = a >> b[4:0];
            4'd10:   o.res = $unsigned($signed(a) >>> b[4:0]);
            default: begin
                o.res = 32'd0;
                o.err = 1'b1;
            end
        endcase
        o.z   = (o.res == 32'd0);
        o.lt  = o.err ? 1'b0 : ($signed(a) < $signed(b));
        o.ltu = o.err ? 1'b0 : (a < b);
        return o;
    endfunction

    alu_out_t alu_now;
    always_comb begin
        alu_now    = alu_fn(alu_a, alu_b, alu_control);
        alu_result = alu_now.res;
        alu_zero   = alu_now.z;
        alu_lt     = alu_now.lt;
        alu_ltu    = alu_now.ltu;
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int checks_cnt = 0;
    int errors_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        int          id;
        logic [31:0] res;
        logic        z;
        logic        lt;
        logic        ltu;
        logic        err;
        bit          shown;
    } ent_t;

    ent_t model_q[$];
    int   model_ptr = 0;
    bit   drop_on_grant = 1'b0;

    function automatic logic [31:0] op_a(input int i);
        logic [NREQ*32-1:0] v;
        v = req_a;
        return v[32*i +: 32];
    endfunction

    function automatic logic [31:0] op_b(input int i);
        logic [NREQ*32-1:0] v;
        v = req_b;
        return v[32*i +: 32];
    endfunction

    function automatic logic [3:0] op_code(input int i);
        logic [NREQ*4-1:0] v;
        v = req_op;
        return v[4*i +: 4];
    endfunction

    // One clock cycle. It is entered 1 time unit after a rising edge, once the
    // inputs for this cycle are set. It leaves 1 time unit after the next
    // rising edge.
    task automatic cycle();
        bit              exp_rv;
        bit              drain;
        bit              acc;
        int              w;
        int              idx;
        logic [NREQ-1:0] exp_ready;
        ent_t            e;
        alu_out_t        r;

        #1;
        exp_rv = (model_q.size() > 0) && model_q[0].shown;
        drain  = exp_rv && rsp_ready;
        acc    = !flush && ((model_q.size() - (drain ? 1 : 0)) < 2);
        w      = -1;
        if (acc) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (model_ptr + k) % NREQ;
                if (w < 0 && req_valid[idx]) w = idx;
            end
        end
        exp_ready = '0;
        if (w >= 0) exp_ready[w] = 1'b1;

        check_val("req_ready", 32'(req_ready), 32'(exp_ready));
        check_val("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        if (exp_rv) begin
            check_val("rsp_id",     32'(rsp_id),   32'(model_q[0].id));
            check_val("rsp_result", rsp_result,    model_q[0].res);
            check_val("rsp_zero",   32'(rsp_zero), 32'(model_q[0].z));
            check_val("rsp_lt",     32'(rsp_lt),   32'(model_q[0].lt));
            check_val("rsp_ltu",    32'(rsp_ltu),  32'(model_q[0].ltu));
            check_val("rsp_err",    32'(rsp_err),  32'(model_q[0].err));
            if (drain) begin
                $display("rsp id=%0d result=%h z=%0b lt=%0b ltu=%0b err=%0b",
                         rsp_id, rsp_result, rsp_zero, rsp_lt, rsp_ltu, rsp_err);
            end
        end

        if (flush) begin
            model_q.delete();
        end else begin
            if (drain) void'(model_q.pop_front());
            if (model_q.size() > 0 && !model_q[0].shown) model_q[0].shown = 1'b1;
            if (w >= 0) begin
                r       = alu_fn(op_a(w), op_b(w), op_code(w));
                e.id    = w;
                e.res   = r.res;
                e.z     = r.z;
                e.lt    = r.lt;
                e.ltu   = r.ltu;
                e.err   = r.err;
                e.shown = 1'b0;
                model_q.push_back(e);
                model_ptr = (w + 1) % NREQ;
            end
        end

        @(posedge clk);
        #1;
        if (drop_on_grant && w >= 0) req_valid[w] = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_op[4*i +: 4]  = op;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_rsp_valid"},  32'(rsp_valid),   32'd0);
        check_val({tag, "_rsp_id"},     32'(rsp_id),      32'd0);
        check_val({tag, "_rsp_result"}, rsp_result,       32'd0);
        check_val({tag, "_rsp_flags"},
                  32'({rsp_zero, rsp_lt, rsp_ltu, rsp_err}), 32'd0);
        check_val({tag, "_alu_a"},      alu_a,            32'd0);
        check_val({tag, "_alu_b"},      alu_b,            32'd0);
        check_val({tag, "_alu_ctl"},    32'(alu_control), 32'd0);
        check_val({tag, "_req_ready"},  32'(req_ready),   32'd0);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'd0;
            2:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        // Reset state
        #3;
        check_all_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all_zero("post_reset");

        // Single op: requester 1, 5 - 3
        rsp_ready = 1'b1;
        drop_on_grant = 1'b1;
        set_req(1, 32'd5, 32'd3, 4'b0001);
        req_valid = 4'b0010;
        repeat (4) cycle();

        // Round robin with all requesters continuously valid
        drop_on_grant = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, $urandom, $urandom, 4'(i));
        req_valid = '1;
        repeat (10) cycle();
        req_valid = '0;
        repeat (3) cycle();

        // Backpressure: three pending ops, consumer stalled
        drop_on_grant = 1'b1;
        for (int i = 0; i < 3; i++) set_req(i, $urandom, $urandom, 4'(i + 8));
        rsp_ready = 1'b0;
        req_valid = 4'b0111;
        repeat (5) cycle();
        rsp_ready = 1'b1;
        repeat (5) cycle();

        // Flags and illegal code
        set_req(0, 32'hFFFF_FFFF, 32'd1, 4'b0101);
        req_valid = 4'b0001;
        repeat (2) cycle();
        set_req(2, 32'h1234_5678, 32'd9, 4'b0111);
        req_valid = 4'b0100;
        repeat (4) cycle();

        // Flush with both stages full
        for (int i = 0; i < NREQ; i++) set_req(i, $urandom, $urandom, 4'd0);
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        repeat (3) cycle();
        req_valid = 4'b1111;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        rsp_ready = 1'b1;
        repeat (6) cycle();

        // Asynchronous reset between clock edges
        drop_on_grant = 1'b0;
        req_valid = 4'b1111;
        repeat (3) cycle();
        req_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_q.delete();
        model_ptr = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_valid = 4'b1110;
        repeat (4) cycle();
        req_valid = '0;
        repeat (2) cycle();

        // Randomized traffic
        drop_on_grant = 1'b1;
        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    set_req(i, rand_operand(), rand_operand(), 4'($urandom_range(0, 15)));
                    req_valid[i] = 1'b1;
                end
            end
            rsp_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 39) == 0);
            cycle();
            flush = 1'b0;
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (4) cycle();

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
